// File: rtl/axi_wr_arbiter_if.sv
// Write-channel bundle between NUM_M AXI masters, the arbiter and one slave.
// slave modport is the arbiter's view, master modport is the environment's.
interface axi_wr_arbiter_if #(
  parameter int NUM_M  = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ID_W   = 4
);
  logic [NUM_M-1:0]        m_awvalid;
  logic [NUM_M-1:0]        m_awready;
  logic [NUM_M*ADDR_W-1:0] m_awaddr;
  logic [NUM_M*ID_W-1:0]   m_awid;
  logic [NUM_M-1:0]        m_wvalid;
  logic [NUM_M-1:0]        m_wlast;
  logic [NUM_M*DATA_W-1:0] m_wdata;
  logic [NUM_M-1:0]        m_wready;
  logic [NUM_M-1:0]        m_bvalid;
  logic [NUM_M-1:0]        m_bready;
  logic [ID_W-1:0]         m_bid;
  logic [1:0]              m_bresp;

  logic                    s_awvalid;
  logic                    s_awready;
  logic [ADDR_W-1:0]       s_awaddr;
  logic [ID_W-1:0]         s_awid;
  logic                    s_wvalid;
  logic                    s_wready;
  logic [DATA_W-1:0]       s_wdata;
  logic                    s_wlast;
  logic                    s_bvalid;
  logic                    s_bready;
  logic [ID_W-1:0]         s_bid;
  logic [1:0]              s_bresp;

  modport slave (
    input  m_awvalid, m_awaddr, m_awid,
    input  m_wvalid, m_wlast, m_wdata,
    input  m_bready,
    output m_awready, m_wready,
    output m_bvalid, m_bid, m_bresp,
    output s_awvalid, s_awaddr, s_awid,
    output s_wvalid, s_wdata, s_wlast,
    output s_bready,
    input  s_awready, s_wready,
    input  s_bvalid, s_bid, s_bresp
  );

  modport master (
    output m_awvalid, m_awaddr, m_awid,
    output m_wvalid, m_wlast, m_wdata,
    output m_bready,
    input  m_awready, m_wready,
    input  m_bvalid, m_bid, m_bresp,
    input  s_awvalid, s_awaddr, s_awid,
    input  s_wvalid, s_wdata, s_wlast,
    input  s_bready,
    output s_awready, s_wready,
    output s_bvalid, s_bid, s_bresp
  );
endinterface

// File: rtl/axi_wr_arbiter.sv
// Round-robin AXI write arbiter: one full AW/W/B transaction per grant.
// Define AXI_ARB_WDOG_EN to add the stall watchdog (limit WDOG_LIMIT).
module axi_wr_arbiter #(
  parameter int NUM_M      = 4,
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int ID_W       = 4,
  parameter int WDOG_LIMIT = 255
) (
  input  logic               ACLK,
  input  logic               ARESETn,
  axi_wr_arbiter_if.slave    bus,
  output logic [NUM_M-1:0]   grant_o,
  output logic               busy_o,
  output logic               err_timeout_o
);

  localparam int IW = (NUM_M > 1) ? $clog2(NUM_M) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ADDR = 2'd1;
  localparam logic [1:0] S_DATA = 2'd2;
  localparam logic [1:0] S_RESP = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [NUM_M-1:0] grant_q, grant_d;
  logic [IW-1:0]    gidx_q, gidx_d;
  logic [IW-1:0]    last_q, last_d;

  logic          in_addr, in_data, in_resp;
  logic          aw_hs, w_hs, b_hs, any_hs;
  logic          win_found;
  logic [IW-1:0] win_idx;
  logic          wdog_fire;

  assign in_addr = (state_q == S_ADDR);
  assign in_data = (state_q == S_DATA);
  assign in_resp = (state_q == S_RESP);

  // Slave-facing request path: only the granted master, only in its phase
  assign bus.s_awvalid = in_addr & bus.m_awvalid[gidx_q];
  assign bus.s_awaddr  = in_addr ?
    bus.m_awaddr[gidx_q*ADDR_W +: ADDR_W] : '0;
  assign bus.s_awid    = in_addr ?
    bus.m_awid[gidx_q*ID_W +: ID_W] : '0;

  assign bus.s_wvalid  = in_data & bus.m_wvalid[gidx_q];
  assign bus.s_wlast   = in_data & bus.m_wlast[gidx_q];
  assign bus.s_wdata   = in_data ?
    bus.m_wdata[gidx_q*DATA_W +: DATA_W] : '0;

  assign bus.s_bready  = in_resp & bus.m_bready[gidx_q];

  // Master-facing return path, masked to the current owner
  assign bus.m_awready = grant_q & {NUM_M{in_addr & bus.s_awready}};
  assign bus.m_wready  = grant_q & {NUM_M{in_data & bus.s_wready}};
  assign bus.m_bvalid  = grant_q & {NUM_M{in_resp & bus.s_bvalid}};
  assign bus.m_bid     = in_resp ? bus.s_bid : '0;
  assign bus.m_bresp   = in_resp ? bus.s_bresp : '0;

  assign aw_hs  = bus.s_awvalid & bus.s_awready;
  assign w_hs   = bus.s_wvalid & bus.s_wready;
  assign b_hs   = bus.s_bvalid & bus.s_bready;
  assign any_hs = aw_hs | w_hs | b_hs;

  assign grant_o = grant_q;
  assign busy_o  = (state_q != S_IDLE);

  // First requester found scanning upward from last_q+1, wrapping
  always_comb begin
    int c;
    logic [IW-1:0] cidx;
    c         = 0;
    cidx      = '0;
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = 1; k <= NUM_M; k++) begin
      c    = (int'(last_q) + k) % NUM_M;
      cidx = IW'(c);
      if (!win_found && bus.m_awvalid[cidx]) begin
        win_found = 1'b1;
        win_idx   = cidx;
      end
    end
  end

`ifdef AXI_ARB_WDOG_EN
  localparam int WW = $clog2(WDOG_LIMIT + 1);

  logic [WW-1:0] wdog_q, wdog_d;
  logic          err_q, err_d;

  always_comb begin
    wdog_fire = busy_o & ~any_hs &
                (wdog_q == WW'(WDOG_LIMIT - 1));
    wdog_d    = wdog_q;
    err_d     = err_q | wdog_fire;
    if (!busy_o || any_hs || wdog_fire)
      wdog_d = '0;
    else
      wdog_d = wdog_q + 1'b1;
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      wdog_q <= '0;
      err_q  <= 1'b0;
    end else begin
      wdog_q <= wdog_d;
      err_q  <= err_d;
    end
  end

  assign err_timeout_o = err_q;
`else
  assign wdog_fire     = 1'b0;
  assign err_timeout_o = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    gidx_d  = gidx_q;
    last_d  = last_q;
    unique case (state_q)
      S_IDLE: begin
        if (win_found) begin
          state_d = S_ADDR;
          gidx_d  = win_idx;
          grant_d = NUM_M'(1) << win_idx;
        end
      end
      S_ADDR: begin
        if (aw_hs)
          state_d = S_DATA;
      end
      S_DATA: begin
        if (w_hs && bus.s_wlast)
          state_d = S_RESP;
      end
      S_RESP: begin
        if (b_hs) begin
          state_d = S_IDLE;
          grant_d = '0;
          last_d  = gidx_q;
        end
      end
      default: begin
        state_d = S_IDLE;
        grant_d = '0;
      end
    endcase
    // Abort of a stalled transaction still rotates priority
    if (wdog_fire) begin
      state_d = S_IDLE;
      grant_d = '0;
      last_d  = gidx_q;
    end
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      gidx_q  <= '0;
      last_q  <= IW'(NUM_M - 1);
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      gidx_q  <= gidx_d;
      last_q  <= last_d;
    end
  end

endmodule

// File: doc/axi_wr_arbiter.md
AXI_WR_ARBITER -- requirements
Module: axi_wr_arbiter

Interface
REQ-001 Parameter NUM_M, default 4, number of requesting masters sharing one slave write port.
REQ-002 Parameter ADDR_W, default 32, AWADDR width.
REQ-003 Parameter DATA_W, default 32, WDATA width.
REQ-004 Parameter ID_W, default 4, AWID/BID width.
REQ-005 Parameter WDOG_LIMIT, default 255, watchdog cycle limit (used only with AXI_ARB_WDOG_EN).
REQ-006 ACLK  in  1  single clock; all state changes on rising edge.
REQ-007 ARESETn  in  1  asynchronous, active-low reset.
REQ-008 m_awvalid  in  NUM_M  per-master AW valid.
REQ-009 m_awready  out  NUM_M  per-master AW ready.
REQ-010 m_awaddr / m_awid  in  NUM_M*ADDR_W / NUM_M*ID_W  flattened AW payloads; master i at slice i.
REQ-011 m_wvalid, m_wlast  in  NUM_M each  per-master W valid / last.
REQ-012 m_wdata  in  NUM_M*DATA_W  flattened W data.
REQ-013 m_wready  out  NUM_M  per-master W ready.
REQ-014 m_bvalid  out  NUM_M; m_bready  in  NUM_M; m_bid  out  ID_W; m_bresp  out  2  B channel back to masters.
REQ-015 s_awvalid/s_awaddr/s_awid, s_wvalid/s_wdata/s_wlast  out; s_awready, s_wready  in  granted request to slave.
REQ-016 s_bvalid, s_bid, s_bresp  in; s_bready  out  slave B channel.
REQ-017 grant_o  out  NUM_M  one-hot current owner, zero in IDLE.
REQ-018 busy_o  out  1  high in any state other than IDLE.
REQ-019 err_timeout_o  out  1  sticky watchdog abort flag.

Function
REQ-020 FSM states IDLE, ADDR, DATA, RESP; one transaction (AW, all W beats, one B) per grant.
REQ-021 IDLE: if any m_awvalid, register round-robin winner into grant_o and enter ADDR next cycle (1-cycle arbitration latency); else stay.
REQ-022 Round-robin: search starts at index last_grant+1 mod NUM_M; after reset last_grant=NUM_M-1, so master 0 has highest priority.
REQ-023 ADDR: s_awvalid/addr/id = granted master's; m_awready[g] = s_awready; on s_awvalid&&s_awready enter DATA.
REQ-024 DATA: s_wvalid/data/last = granted master's; m_wready[g] = s_wready; on handshake with wlast=1 enter RESP; non-last beats stay in DATA.
REQ-025 RESP: m_bvalid[g]=s_bvalid, m_bid=s_bid, m_bresp=s_bresp, s_bready=m_bready[g]; on handshake return to IDLE and set last_grant=g.
REQ-026 Non-granted masters: awready, wready, bvalid held 0 at all times.
REQ-027 Slave-side valids (s_awvalid, s_wvalid) and s_bready are 0 outside their respective state.
REQ-028 Master deasserting awvalid in ADDR before handshake: arbiter holds grant (AXI violation not tolerated silently; no state change).
REQ-029 W beats presented before grant are not forwarded; W ordering follows AW grant order.
REQ-030 Simultaneous requests from all masters: each granted exactly once in 4 consecutive transactions, order 0,1,2,3 after reset.
REQ-031 Back-to-back: B handshake in RESP and new awvalid produce next grant one cycle after IDLE entry.

Reset
REQ-032 ARESETn low asynchronously forces IDLE, grant_o=0, busy_o=0, err_timeout_o=0, last_grant=NUM_M-1, all ready/valid outputs 0.
REQ-033 Reset mid-transaction abandons it; no B is delivered afterwards for the aborted transaction.

Configuration
REQ-034 Macro AXI_ARB_WDOG_EN defined: counter increments each cycle in ADDR/DATA/RESP without handshake, clears on any handshake; at WDOG_LIMIT force IDLE, set err_timeout_o (cleared only by reset), advance last_grant.
REQ-035 AXI_ARB_WDOG_EN undefined: no counter, err_timeout_o tied 0, FSM waits indefinitely.

Verification
REQ-036 Single write: m0 AW 0x0000_0100 id 0, one W 0x1111_1111 last -> slave sees same, m_bvalid[0] with bid 0, bresp 00; grant_o 0001 then 0000.
REQ-037 All four request together after reset -> grant_o sequence 0001,0010,0100,1000; slave AWIDs 0,1,2,3.
REQ-038 4-beat burst from m2 while m1 requests -> m1 gets no awready until m2 B handshake; then grant_o 0010.
REQ-039 Slave holds s_bvalid low -> RESP held; with AXI_ARB_WDOG_EN, WDOG_LIMIT=16: IDLE after 16 idle cycles, err_timeout_o=1.
REQ-040 ARESETn pulsed low during DATA of m3 -> all outputs 0 immediately; next request from m0 granted first.
